// File: rtl/rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter
//
// N-way round-robin arbiter with grant locking and a bounded hold time.
// One shared resource is handed to one requester at a time. The owner keeps
// the grant for as long as it holds its request. After MAX_HOLD consecutive
// grant cycles it is forcibly released, but only if some other requester is
// waiting. With no competitors the owner may hold indefinitely.
//
// Every change of owner passes through an IDLE cycle with no grant, so two
// grants never overlap and there is never a same-edge handover. The search
// pointer moves past the owner whenever that owner releases or is preempted,
// so the requester that just finished has lowest priority in the next
// arbitration. Requests from non-owners are not latched during ownership.
//
// Parameters
//   N         number of requesters (2..16)
//   MAX_HOLD  grant cycles before a forced release when others wait (>= 2)
//   ID_W      width of o_gnt_id (derived)
//   CNT_W     width of the hold counter (derived)
//
// Ports
//   i_clock      system clock; all state changes on the rising edge
//   i_reset      synchronous, active-high reset
//   i_req        request vector; bit i belongs to requester i, level-sensitive
//   o_gnt        registered one-hot (or all-zero) grant vector
//   o_gnt_valid  registered OR of o_gnt
//   o_gnt_id     index of the granted requester; 0 when o_gnt_valid is 0
//   o_preempt    one-cycle pulse: the owner was released by hold timeout
// -----------------------------------------------------------------------------
module rr_lock_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N),
  localparam int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_gnt,
  output logic            o_gnt_valid,
  output logic [ID_W-1:0] o_gnt_id,
  output logic            o_preempt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam logic [ID_W:0]    N_L     = (ID_W+1)'(N);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [N-1:0]      r_gnt;
  logic              r_gnt_valid;
  logic [ID_W-1:0]   r_gnt_id;
  logic              r_preempt;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [N-1:0]      w_gnt_nxt;
  logic [ID_W-1:0]   w_gnt_id_nxt;
  logic              w_preempt_nxt;

  // ---------------------------------------------------------------------------
  // Round-robin pick
  //
  // The request vector is rotated right by r_ptr so that bit 0 of the rotated
  // vector is the highest-priority requester. The lowest set bit of the
  // rotated vector gives the offset from r_ptr; adding it back modulo N gives
  // the absolute index of the winner.
  // ---------------------------------------------------------------------------
  logic [2*N-1:0]    w_req_dbl;
  logic [2*N-1:0]    w_req_shift;
  logic [N-1:0]      w_req_rot;
  logic [ID_W-1:0]   w_pick_off;
  logic [ID_W:0]     w_pick_sum;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_any_req;

  assign w_req_dbl   = {i_req, i_req};
  assign w_req_shift = w_req_dbl >> r_ptr;
  assign w_req_rot   = w_req_shift[N-1:0];
  assign w_any_req   = |i_req;

  always_comb begin
    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    w_pick_off = '0;
    // Scan from the top down: the last hit written is the lowest set bit.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_pick_off = ID_W'(i);
      end
    end
  end

  assign w_pick_sum = {1'b0, r_ptr} + {1'b0, w_pick_off};
  assign w_pick_id  = (w_pick_sum >= N_L) ? ID_W'(w_pick_sum - N_L)
                                          : ID_W'(w_pick_sum);

  // ---------------------------------------------------------------------------
  // Owner status
  //
  // r_gnt is one-hot while owning, so masking with it selects the owner's own
  // request bit and masking with its complement selects the competitors.
  // ---------------------------------------------------------------------------
  logic              w_owner_req;
  logic              w_others_req;
  logic [ID_W-1:0]   w_ptr_after;
  logic              w_hold_done;

  assign w_owner_req  = |(i_req & r_gnt);
  assign w_others_req = |(i_req & ~r_gnt);
  assign w_ptr_after  = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + 1'b1;
  assign w_hold_done  = (r_cnt == CNT_MAX);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_preempt_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
        if (w_any_req) begin
          w_gnt_nxt    = N'(1) << w_pick_id;
          w_gnt_id_nxt = w_pick_id;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_OWN;
        end
      end

      ST_OWN: begin
        if (!w_owner_req) begin
          // Voluntary release.
          w_gnt_nxt    = '0;
          w_gnt_id_nxt = '0;
          w_ptr_nxt    = w_ptr_after;
          w_state_nxt  = ST_IDLE;
        end else if (w_hold_done && w_others_req) begin
          // Hold budget used up and someone else is waiting.
          w_gnt_nxt     = '0;
          w_gnt_id_nxt  = '0;
          w_ptr_nxt     = w_ptr_after;
          w_preempt_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (!w_hold_done) begin
          // Counter saturates so a lone owner can hold forever.
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_preempt   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_preempt   <= w_preempt_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_id    = r_gnt_id;
  assign o_preempt   = r_preempt;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_lock_arbiter
//
// Self-checking bench for rr_lock_arbiter with N=4, MAX_HOLD=4. Each cycle
// drives i_req/i_reset on the falling edge, advances a behavioural model and
// pushes the expected outputs onto a scoreboard queue; 1 ns after the rising
// edge the entry is popped and compared against the DUT. Directed scenarios
// additionally check the order of grant owners and the number of preemptions.
// -----------------------------------------------------------------------------
module tb_rr_lock_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int ID_W     = $clog2(N);

  typedef struct packed {
    logic [N-1:0]    gnt;
    logic            valid;
    logic [ID_W-1:0] id;
    logic            preempt;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic            preempt;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];

  // Behavioural model state: owner index and number of granted cycles so far.
  bit m_own;
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_preempt;

  // Observations for directed checks.
  int   grant_log[$];
  int   preempt_cnt;
  logic prev_valid;

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_gnt_valid (gnt_valid),
    .o_gnt_id    (gnt_id),
    .o_preempt   (preempt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic rst);
    m_preempt = 1'b0;
    if (rst) begin
      m_own = 1'b0; m_owner = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_own) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!m_own && r[idx]) begin
          m_own = 1'b1; m_owner = idx; m_hold = 1;
        end
      end
    end else begin
      logic [N-1:0] others;
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_own = 1'b0; m_ptr = (m_owner + 1) % N;
      end else if (m_hold >= MAX_HOLD && others != '0) begin
        m_own = 1'b0; m_ptr = (m_owner + 1) % N; m_preempt = 1'b1;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.gnt     = m_own ? (N'(1) << m_owner) : '0;
    e.valid   = m_own;
    e.id      = m_own ? ID_W'(m_owner) : '0;
    e.preempt = m_preempt;
    return e;
  endfunction

  task automatic cycle(input logic [N-1:0] r, input logic rst);
    exp_t e;
    @(negedge clock);
    req   = r;
    reset = rst;
    model_step(r, rst);
    sb_q.push_back(model_out());
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("gnt",       32'(gnt),       32'(e.gnt));
      check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
      check("gnt_id",    32'(gnt_id),    32'(e.id));
      check("preempt",   32'(preempt),   32'(e.preempt));
    end
    if (gnt_valid && !prev_valid) grant_log.push_back(int'(gnt_id));
    if (preempt) preempt_cnt++;
    prev_valid = gnt_valid;
  endtask

  task automatic start_scenario();
    grant_log.delete();
    preempt_cnt = 0;
    cycle('0, 1'b1);
  endtask

  task automatic check_log(input string tag, input int exp_ids[$]);
    check({tag, "_ngrants"}, 32'(grant_log.size()), 32'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < grant_log.size(); i++)
      check({tag, "_owner"}, 32'(grant_log[i]), 32'(exp_ids[i]));
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    prev_valid = 1'b0;

    // Reset state.
    start_scenario();
    cycle('0, 1'b1);
    check("reset_gnt", 32'(gnt), 32'd0);

    // S1: single requester, release, then pointer sits at 3.
    start_scenario();
    repeat (3) cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    repeat (2) cycle(4'b1001, 1'b0);
    cycle(4'b0000, 1'b0);
    check_log("s1", '{2, 3});

    // S2: all requesting, rotation 0..3..0 with a preemption after each grant.
    start_scenario();
    repeat (25) cycle(4'b1111, 1'b0);
    check_log("s2", '{0, 1, 2, 3, 0});
    check("s2_preempts", 32'(preempt_cnt), 32'd5);

    // S3: lone requester holds past the hold limit, never preempted.
    start_scenario();
    repeat (20) cycle(4'b0001, 1'b0);
    check("s3_preempts", 32'(preempt_cnt), 32'd0);
    check("s3_gnt_end", 32'(gnt), 32'b0001);

    // S4: competitor arrives mid-hold, owner 0 preempted, requester 3 next.
    start_scenario();
    repeat (2) cycle(4'b0001, 1'b0);
    repeat (6) cycle(4'b1001, 1'b0);
    check_log("s4", '{0, 3});
    check("s4_preempts", 32'(preempt_cnt), 32'd1);

    // S5: owner 1 releases; ptr=2 wraps so requester 0 beats requester 1.
    start_scenario();
    repeat (3) cycle(4'b0010, 1'b0);
    cycle(4'b0001, 1'b0);
    repeat (2) cycle(4'b0011, 1'b0);
    check_log("s5", '{1, 0});
    check("s5_preempts", 32'(preempt_cnt), 32'd0);

    // S6: reset while owner 1 is mid-hold; pointer returns to 0.
    start_scenario();
    repeat (2) cycle(4'b0010, 1'b0);
    cycle(4'b0011, 1'b1);
    check("s6_reset_valid", 32'(gnt_valid), 32'd0);
    repeat (2) cycle(4'b0011, 1'b0);
    check_log("s6", '{1, 0});

    // Random traffic with occasional resets.
    begin
      logic [N-1:0] r;
      logic [31:0]  rnd;
      r = '0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rnd = $urandom();
          r   = rnd[N-1:0];
        end
        cycle(r, ($urandom_range(0, 99) == 0));
      end
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the run is bounded, this only fires if stimulus stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
